// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer
// Steps one 128-bit block through a full AES encryption. It holds the state
// matrix in a register and issues one operation per cycle to the shared
// combinational aes_operations_unit, in AES round order. Round keys are
// fetched from an external key store through a valid-qualified request.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   start         begin encrypting block_in (accepted only when idle)
//   abort         synchronous cancel back to idle, no done pulse
//   block_in      plaintext, lane 0 = column 0, byte [31:24] = row 0
//   key_req       a round key is needed this cycle
//   key_round     index of the requested round key
//   key_valid     key_data holds the key for key_round this cycle
//   key_data      round key from the key store
//   op_operand1   state register to the ops unit
//   op_operand2   round key during AddRoundKey, zero otherwise
//   op_select     operation code to the ops unit
//   op_result     combinational result from the ops unit
//   busy          encryption in progress
//   done          one-cycle pulse, block_out holds the ciphertext
//   block_out     state register (ciphertext after done)
module aes_round_sequencer #(
  parameter int regSize = 32,
  parameter int vecSize = 4,
  parameter int NR      = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              abort,
  input  logic [vecSize-1:0][regSize-1:0]   block_in,
  output logic                              key_req,
  output logic [3:0]                        key_round,
  input  logic                              key_valid,
  input  logic [vecSize-1:0][regSize-1:0]   key_data,
  output logic [vecSize-1:0][regSize-1:0]   op_operand1,
  output logic [vecSize-1:0][regSize-1:0]   op_operand2,
  output logic [2:0]                        op_select,
  input  logic [vecSize-1:0][regSize-1:0]   op_result,
  output logic                              busy,
  output logic                              done,
  output logic [vecSize-1:0][regSize-1:0]   block_out
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b010;
  localparam logic [2:0] OP_SHIFT = 3'b011;
  localparam logic [2:0] OP_MIX   = 3'b100;
  localparam logic [2:0] OP_ARK   = 3'b101;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  typedef enum logic [2:0] {
    IDLE,
    ARK0,
    SUB,
    SHIFT,
    MIX,
    ARK,
    DONE
  } state_t;

  state_t                            state_q, state_d;
  logic [vecSize-1:0][regSize-1:0]   data_q, data_d;
  logic [3:0]                        round_q, round_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    round_d     = round_q;
    op_select   = OP_NOP;
    op_operand2 = '0;
    key_req     = 1'b0;
    key_round   = '0;
    busy        = 1'b0;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          data_d  = block_in;
          round_d = 4'd1;
          state_d = ARK0;
        end
      end
      ARK0: begin
        busy        = 1'b1;
        op_select   = OP_ARK;
        op_operand2 = key_data;
        key_req     = 1'b1;
        key_round   = '0;
        if (key_valid) begin
          data_d  = op_result;
          state_d = SUB;
        end
      end
      SUB: begin
        busy      = 1'b1;
        op_select = OP_SUB;
        data_d    = op_result;
        state_d   = SHIFT;
      end
      SHIFT: begin
        busy      = 1'b1;
        op_select = OP_SHIFT;
        data_d    = op_result;
        // The final round skips MixColumns.
        state_d   = (round_q < LAST_ROUND) ? MIX : ARK;
      end
      MIX: begin
        busy      = 1'b1;
        op_select = OP_MIX;
        data_d    = op_result;
        state_d   = ARK;
      end
      ARK: begin
        busy        = 1'b1;
        op_select   = OP_ARK;
        op_operand2 = key_data;
        key_req     = 1'b1;
        key_round   = round_q;
        if (key_valid) begin
          data_d = op_result;
          if (round_q == LAST_ROUND) begin
            state_d = DONE;
          end else begin
            round_d = round_q + 4'd1;
            state_d = SUB;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Cancel overrides every transition and leaves the state matrix intact.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      data_d  = data_q;
      round_d = round_q;
    end
  end

  assign op_operand1 = data_q;
  assign block_out   = data_q;

endmodule

// File: tb/tb_aes_round_sequencer.sv
module tb_aes_round_sequencer;
  typedef logic [3:0][31:0] blk_t;
  localparam int NR_A = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic start_a, abort_a, key_req_a, key_valid_a, busy_a, done_a;
  logic [3:0] key_round_a;
  logic [2:0] op_select_a;
  blk_t block_in_a, key_data_a, op_operand1_a, op_operand2_a, op_result_a, block_out_a;

  logic start_b, abort_b, key_req_b, key_valid_b, busy_b, done_b;
  logic [3:0] key_round_b;
  logic [2:0] op_select_b;
  blk_t block_in_b, key_data_b, op_operand1_b, op_operand2_b, op_result_b, block_out_b;

  blk_t rk [0:14];
  int checks = 0;
  int errors = 0;
  blk_t ct_q[$];
  int   cyc_q[$];
  blk_t fips_pt, fips_ct;

  // ---------------- AES reference functions (also serve as the ops unit) ----
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xt(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254, then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 7; i >= 0; i--) begin
      r = gmul(r, r);
      if (i != 0) r = gmul(r, x);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] gb(input blk_t b, input int r, input int c);
    return b[c][31-8*r -: 8];
  endfunction

  function automatic blk_t sub_bytes(input blk_t b);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[c][31-8*r -: 8] = sbox(gb(b, r, c));
    return o;
  endfunction

  function automatic blk_t shift_rows(input blk_t b);
    blk_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) o[c][31-8*r -: 8] = gb(b, r, (c + r) % 4);
    return o;
  endfunction

  function automatic blk_t mix_columns(input blk_t b);
    blk_t o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(b, 0, c); a1 = gb(b, 1, c); a2 = gb(b, 2, c); a3 = gb(b, 3, c);
      o[c] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
              xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o;
  endfunction

  function automatic blk_t aes_op(input logic [2:0] sel, input blk_t a, input blk_t k);
    case (sel)
      3'b010:  return sub_bytes(a);
      3'b011:  return shift_rows(a);
      3'b100:  return mix_columns(a);
      3'b101:  return a ^ k;
      default: return '0;
    endcase
  endfunction

  function automatic blk_t ref_encrypt(input blk_t pt, input int nr);
    blk_t s;
    s = pt ^ rk[0];
    for (int r = 1; r <= nr; r++) begin
      s = shift_rows(sub_bytes(s));
      if (r < nr) s = mix_columns(s);
      s = s ^ rk[r];
    end
    return s;
  endfunction

  task automatic expand_key();
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    w[0] = 32'h00010203; w[1] = 32'h04050607; w[2] = 32'h08090a0b; w[3] = 32'h0c0d0e0f;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 4; c++) rk[r][c] = (r <= 10) ? w[4*r+c] : 32'h0;
  endtask

  // ---------------- ops unit and key store ----------------
  assign op_result_a = aes_op(op_select_a, op_operand1_a, op_operand2_a);
  assign key_data_a  = rk[key_round_a];
  assign op_result_b = aes_op(op_select_b, op_operand1_b, op_operand2_b);
  assign key_data_b  = rk[key_round_b];

  aes_round_sequencer #(.regSize(32), .vecSize(4), .NR(NR_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .block_in(block_in_a),
    .key_req(key_req_a), .key_round(key_round_a), .key_valid(key_valid_a),
    .key_data(key_data_a), .op_operand1(op_operand1_a), .op_operand2(op_operand2_a),
    .op_select(op_select_a), .op_result(op_result_a), .busy(busy_a), .done(done_a),
    .block_out(block_out_a)
  );

  aes_round_sequencer #(.regSize(32), .vecSize(4), .NR(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .block_in(block_in_b),
    .key_req(key_req_b), .key_round(key_round_b), .key_valid(key_valid_b),
    .key_data(key_data_b), .op_operand1(op_operand1_b), .op_operand2(op_operand2_b),
    .op_select(op_select_b), .op_result(op_result_b), .busy(busy_b), .done(done_b),
    .block_out(block_out_b)
  );

  // One encryption on instance A. Cycle c is the cycle after edge c-1, where
  // edge 0 samples start. Optional key stall window, ignored start, abort.
  task automatic run_enc(input blk_t pt, input blk_t exp_ct, input int stall_at,
                         input int stall_len, input int start_at, input int abort_at,
                         input string tag);
    logic [2:0] exp_ops[$];
    blk_t exp_state, exp_op2, pc;
    int idx, ark_n, pcyc;
    bit finished;
    idx = 0; ark_n = 0; finished = 1'b0;
    exp_ops.push_back(3'b101);
    for (int r = 1; r <= NR_A; r++) begin
      exp_ops.push_back(3'b010);
      exp_ops.push_back(3'b011);
      if (r < NR_A) exp_ops.push_back(3'b100);
      exp_ops.push_back(3'b101);
    end
    if (abort_at == 0) begin
      ct_q.push_back(exp_ct);
      cyc_q.push_back(4 * NR_A + 1 + stall_len);
    end
    block_in_a = pt; start_a = 1'b1; key_valid_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    exp_state = pt;
    for (int c = 1; c <= 200 && !finished; c++) begin
      key_valid_a = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      start_a     = (c == start_at);
      abort_a     = (c == abort_at);
      block_in_a  = (c == start_at) ? ~pt : pt;
      @(negedge clk);
      checks++;
      if (block_out_a !== exp_state) begin
        errors++; $display("FAIL %s state c=%0d got %h exp %h", tag, c, block_out_a, exp_state);
      end
      if (abort_at != 0 && c == abort_at + 1) begin
        checks++;
        if ({busy_a, done_a, key_req_a, op_select_a} !== 6'b0) begin
          errors++; $display("FAIL %s abort c=%0d got busy=%b done=%b kreq=%b op=%b exp all 0",
                             tag, c, busy_a, done_a, key_req_a, op_select_a);
        end
        finished = 1'b1;
      end else if (idx < exp_ops.size()) begin
        exp_op2 = (exp_ops[idx] == 3'b101) ? rk[ark_n] : '0;
        checks++;
        if ({busy_a, done_a, op_select_a} !== {2'b10, exp_ops[idx]}) begin
          errors++; $display("FAIL %s opseq c=%0d got busy=%b done=%b op=%b exp busy=1 done=0 op=%b",
                             tag, c, busy_a, done_a, op_select_a, exp_ops[idx]);
        end
        checks++;
        if (op_operand2_a !== exp_op2) begin
          errors++; $display("FAIL %s operand2 c=%0d got %h exp %h", tag, c, op_operand2_a, exp_op2);
        end
        if (exp_ops[idx] == 3'b101) begin
          checks++;
          if (key_req_a !== 1'b1 || key_round_a !== 4'(ark_n)) begin
            errors++; $display("FAIL %s keyreq c=%0d got req=%b round=%0d exp req=1 round=%0d",
                               tag, c, key_req_a, key_round_a, ark_n);
          end
        end else begin
          checks++;
          if (key_req_a !== 1'b0) begin
            errors++; $display("FAIL %s keyreq c=%0d got %b exp 0", tag, c, key_req_a);
          end
        end
        if (c != abort_at && (exp_ops[idx] != 3'b101 || key_valid_a)) begin
          exp_state = aes_op(exp_ops[idx], exp_state, exp_op2);
          if (exp_ops[idx] == 3'b101) ark_n++;
          idx++;
        end
      end else begin
        checks++;
        if ({busy_a, done_a, op_select_a} !== 5'b01000) begin
          errors++; $display("FAIL %s donecyc c=%0d got busy=%b done=%b op=%b exp busy=0 done=1 op=000",
                             tag, c, busy_a, done_a, op_select_a);
        end
        checks++;
        if (ct_q.size() == 0) begin
          errors++; $display("FAIL %s scoreboard got done exp none", tag);
        end else begin
          pc = ct_q.pop_front(); pcyc = cyc_q.pop_front();
          if (block_out_a !== pc || c != pcyc) begin
            errors++; $display("FAIL %s cipher got %h at cycle %0d exp %h at cycle %0d",
                               tag, block_out_a, c, pc, pcyc);
          end
        end
        finished = 1'b1;
      end
      if (!finished) begin @(posedge clk); #1; end
    end
    if (!finished) begin
      checks++; errors++; $display("FAIL %s timeout got no completion exp done", tag);
    end
    start_a = 1'b0; abort_a = 1'b0; key_valid_a = 1'b1; block_in_a = pt;
    // Quiet period: no stray done, idle flags, output held.
    for (int k = 0; k < ((abort_at != 0) ? 4 : 1); k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || op_select_a !== 3'b000) begin
        errors++; $display("FAIL %s after got done=%b busy=%b op=%b exp 0 0 000",
                           tag, done_a, busy_a, op_select_a);
      end
      if (abort_at == 0) begin
        checks++;
        if (block_out_a !== exp_ct) begin
          errors++; $display("FAIL %s hold got %h exp %h", tag, block_out_a, exp_ct);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; key_valid_a = 1'b1; block_in_a = '0;
    start_b = 1'b0; abort_b = 1'b0; key_valid_b = 1'b1; block_in_b = '0;
    expand_key();
    #13;
    checks++;
    if ({busy_a, done_a, key_req_a, key_round_a, op_select_a} !== 10'b0 || block_out_a !== '0) begin
      errors++; $display("FAIL reset_a got busy=%b done=%b kreq=%b kr=%0d op=%b out=%h exp zeros",
                         busy_a, done_a, key_req_a, key_round_a, op_select_a, block_out_a);
    end
    checks++;
    if ({busy_b, done_b, key_req_b, key_round_b, op_select_b} !== 10'b0 || block_out_b !== '0) begin
      errors++; $display("FAIL reset_b got busy=%b done=%b op=%b out=%h exp zeros",
                         busy_b, done_b, op_select_b, block_out_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    run_enc(fips_pt, fips_ct, 0, 0, 0, 0, "fips");
  endtask

  task automatic test_key_stall();
    run_enc(fips_pt, fips_ct, 13, 5, 0, 0, "stall");
  endtask

  task automatic test_back_to_back();
    blk_t pt2;
    for (int i = 0; i < 4; i++) pt2[i] = $urandom();
    run_enc(fips_pt, fips_ct, 0, 0, 20, 0, "start_ignored");
    run_enc(pt2, ref_encrypt(pt2, NR_A), 0, 0, 0, 0, "back_to_back");
  endtask

  task automatic test_abort();
    run_enc(fips_pt, fips_ct, 0, 0, 0, 15, "abort");
    run_enc(fips_pt, fips_ct, 0, 0, 0, 0, "after_abort");
  endtask

  task automatic test_reset_mid();
    block_in_a = fips_pt; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (24) @(posedge clk);
    #3;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++; $display("FAIL reset_mid busy_before got %b exp 1", busy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, key_req_a, key_round_a, op_select_a} !== 10'b0 || block_out_a !== '0) begin
      errors++; $display("FAIL reset_mid async got busy=%b done=%b kreq=%b kr=%0d op=%b out=%h exp zeros",
                         busy_a, done_a, key_req_a, key_round_a, op_select_a, block_out_a);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
        errors++; $display("FAIL reset_mid hold got done=%b busy=%b exp 0 0", done_a, busy_a);
      end
    end
    rst_n = 1'b1;
    run_enc(fips_pt, fips_ct, 0, 0, 0, 0, "after_reset");
  endtask

  task automatic test_nr1();
    logic [2:0] ops [0:3];
    blk_t pt, pc;
    int pcyc;
    bit got;
    ops[0] = 3'b101; ops[1] = 3'b010; ops[2] = 3'b011; ops[3] = 3'b101;
    for (int v = 0; v < 2; v++) begin
      if (v == 0) pt = fips_pt;
      else for (int i = 0; i < 4; i++) pt[i] = $urandom();
      ct_q.push_back(ref_encrypt(pt, 1));
      cyc_q.push_back(5);
      block_in_b = pt; start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      got = 1'b0;
      for (int c = 1; c <= 20 && !got; c++) begin
        @(negedge clk);
        if (c <= 4) begin
          checks++;
          if ({busy_b, done_b, op_select_b} !== {2'b10, ops[c-1]}) begin
            errors++; $display("FAIL nr1 opseq c=%0d got busy=%b done=%b op=%b exp 1 0 %b",
                               c, busy_b, done_b, op_select_b, ops[c-1]);
          end
        end else if (done_b === 1'b1) begin
          got = 1'b1;
          pc = ct_q.pop_front(); pcyc = cyc_q.pop_front();
          checks++;
          if (block_out_b !== pc || c != pcyc || busy_b !== 1'b0) begin
            errors++; $display("FAIL nr1 cipher got %h at cycle %0d busy=%b exp %h at cycle %0d",
                               block_out_b, c, busy_b, pc, pcyc);
          end
        end
      end
      if (!got) begin
        checks++; errors++; $display("FAIL nr1 timeout got no done exp done");
        void'(ct_q.pop_front()); void'(cyc_q.pop_front());
      end
      @(negedge clk);
    end
  endtask

  initial begin
    fips_pt[0] = 32'h00112233; fips_pt[1] = 32'h44556677;
    fips_pt[2] = 32'h8899aabb; fips_pt[3] = 32'hccddeeff;
    fips_ct[0] = 32'h69c4e0d8; fips_ct[1] = 32'h6a7b0430;
    fips_ct[2] = 32'hd8cdb780; fips_ct[3] = 32'h70b4c55a;
    test_reset();
    test_fips();
    test_key_stall();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    test_nr1();
    checks++;
    if (ct_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_left got %0d entries exp 0", ct_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
